// File: rtl/imager_tx_if.sv
// Token stream into imager_tx: dtype-tagged data with a registered stall back to the source.
// The dtype codes live here so that every user of the stream sees the same values.
`ifndef IMAGER_TX_DTYPES
`define IMAGER_TX_DTYPES
`define DTYPE_WIDTH     4
`define DT_FRAME_START  4'h1
`define DT_FRAME_END    4'h2
`define DT_ROW_START    4'h3
`define DT_ROW_END      4'h4
`define DT_PIXEL        4'h5
`define DT_HEADER_START 4'h6
`define DT_HEADER       4'h7
`define DT_HEADER_END   4'h8
`endif

interface imager_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    dvi;
    logic [`DTYPE_WIDTH-1:0] dtypei;
    logic [DATA_WIDTH-1:0]   datai;
    logic                    stall;

    modport master (output dvi, dtypei, datai, input stall);
    modport slave  (input dvi, dtypei, datai, output stall);
endinterface

// File: rtl/imager_tx.sv
// Rebuilds parallel sensor video (fv/lv/dvo/datao) from a dtype-tagged token stream,
// buffered through a small token FIFO with programmable blanking and fv lead time.
module imager_tx #(
    parameter int PIXEL_WIDTH = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clki,
    input  logic                   reset_clki,
    input  logic                   enable,
    input  logic                   left_justify,
    input  logic [15:0]            hblank,
    input  logic [15:0]            vblank,
    input  logic [7:0]             fv_lead,
    imager_tx_if.slave             strm,
    output logic                   overflow,
    output logic [15:0]            frame_count,
    output logic                   fv,
    output logic                   lv,
    output logic                   dvo,
    output logic [PIXEL_WIDTH-1:0] datao
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {K_FS, K_RS, K_PX, K_RE, K_FE} kind_t;
    typedef struct packed {
        kind_t                  kind;
        logic [PIXEL_WIDTH-1:0] pix;
    } tok_t;
    typedef enum logic [2:0] {IDLE, LEAD, FRAME, LINE, HBLANK, VBLANK} state_t;

    logic                   accept, known, wr_req, push, pop, full, empty, stall;
    kind_t                  wr_kind;
    logic [PIXEL_WIDTH-1:0] wr_pix;
    tok_t                   mem [FIFO_DEPTH];
    tok_t                   head;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, count_next;

    state_t                 st, st_n;
    logic [15:0]            tmr, tmr_n;
    logic                   fv_n, lv_n, dvo_n, fc_inc;
    logic [PIXEL_WIDTH-1:0] dat_n;

    // Write side: only frame/row/pixel tokens are kept, and only inside an accepted frame.
    always_comb begin
        known   = 1'b1;
        wr_kind = K_PX;
        case (strm.dtypei)
            `DT_FRAME_START: wr_kind = K_FS;
            `DT_ROW_START:   wr_kind = K_RS;
            `DT_PIXEL:       wr_kind = K_PX;
            `DT_ROW_END:     wr_kind = K_RE;
            `DT_FRAME_END:   wr_kind = K_FE;
            default:         known   = 1'b0;
        endcase
        wr_pix = left_justify ? strm.datai[DATA_WIDTH-1 -: PIXEL_WIDTH]
                              : strm.datai[PIXEL_WIDTH-1:0];
        wr_req = strm.dvi && known && (accept || (wr_kind == K_FS && enable));
    end

    // full is judged before this cycle's pop, so a push onto a full FIFO is always lost.
    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = wr_req && !full;
    assign head       = mem[rd_ptr];
    assign count_next = count + CW'(push) - CW'(pop);
    assign strm.stall = stall;

    always_ff @(posedge clki) begin
        if (push) mem[wr_ptr] <= tok_t'{wr_kind, wr_pix};
    end

    always_comb begin
        st_n   = st;
        tmr_n  = tmr;
        pop    = 1'b0;
        fv_n   = fv;
        lv_n   = lv;
        dvo_n  = 1'b0;
        dat_n  = '0;
        fc_inc = 1'b0;
        case (st)
            IDLE: begin
                fv_n = 1'b0;
                lv_n = 1'b0;
                if (!empty) begin
                    pop = 1'b1;
                    if (head.kind == K_FS) begin
                        fv_n   = 1'b1;
                        fc_inc = 1'b1;
                        tmr_n  = {8'd0, fv_lead};
                        st_n   = (fv_lead == 8'd0) ? FRAME : LEAD;
                    end
                end
            end
            LEAD: begin
                if (tmr <= 16'd1) st_n = FRAME;
                else              tmr_n = tmr - 16'd1;
            end
            FRAME: begin
                if (!empty) begin
                    case (head.kind)
                        K_RS: begin
                            pop  = 1'b1;
                            lv_n = 1'b1;
                            st_n = LINE;
                        end
                        K_FE, K_FS: begin
                            // A new FRAME_START stays queued for IDLE to pick up.
                            pop   = (head.kind == K_FE);
                            fv_n  = 1'b0;
                            tmr_n = vblank;
                            st_n  = (vblank == 16'd0) ? IDLE : VBLANK;
                        end
                        default: pop = 1'b1;
                    endcase
                end
            end
            LINE: begin
                if (!empty) begin
                    case (head.kind)
                        K_PX: begin
                            pop   = 1'b1;
                            dvo_n = 1'b1;
                            dat_n = head.pix;
                        end
                        K_RE, K_RS: begin
                            // A ROW_START here closes the current row and waits for FRAME.
                            pop   = (head.kind == K_RE);
                            lv_n  = 1'b0;
                            tmr_n = hblank;
                            st_n  = (hblank == 16'd0) ? FRAME : HBLANK;
                        end
                        default: begin
                            pop   = (head.kind == K_FE);
                            lv_n  = 1'b0;
                            fv_n  = 1'b0;
                            tmr_n = vblank;
                            st_n  = (vblank == 16'd0) ? IDLE : VBLANK;
                        end
                    endcase
                end
            end
            HBLANK: begin
                if (tmr <= 16'd1) st_n = FRAME;
                else              tmr_n = tmr - 16'd1;
            end
            VBLANK: begin
                if (tmr <= 16'd1) st_n = IDLE;
                else              tmr_n = tmr - 16'd1;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clki) begin
        if (reset_clki) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            stall       <= 1'b0;
            overflow    <= 1'b0;
            accept      <= 1'b0;
            st          <= IDLE;
            tmr         <= '0;
            fv          <= 1'b0;
            lv          <= 1'b0;
            dvo         <= 1'b0;
            datao       <= '0;
            frame_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            stall <= (count_next >= CW'(FIFO_DEPTH - 2));
            if (wr_req && full) overflow <= 1'b1;
            if (wr_req && wr_kind == K_FS && enable) accept <= 1'b1;
            else if (wr_req && wr_kind == K_FE)      accept <= 1'b0;
            st    <= st_n;
            tmr   <= tmr_n;
            fv    <= fv_n;
            lv    <= lv_n;
            dvo   <= dvo_n;
            datao <= dat_n;
            if (fc_inc) frame_count <= frame_count + 16'd1;
        end
    end
endmodule

// File: doc/imager_tx.md
Name: imager_tx

Overview:
- Inverse of the imager receive path: consumes a dtype-tagged pixel stream (FRAME_START/ROW_START/PIXEL/ROW_END/FRAME_END/HEADER*) and regenerates parallel sensor-style video: fv, lv, dvo, datao.
- Used for image-sensor emulation, loopback of the processing pipeline, and driving downstream parallel-video consumers.
- An input token FIFO decouples the bursty stream from the output timing. The upstream is throttled with `stall`.
- Horizontal/vertical blanking and fv-to-first-lv lead time are programmable.

Parameters:
- PIXEL_WIDTH, 12, output pixel width.
- DATA_WIDTH, 16, input stream data width; must be >= PIXEL_WIDTH.
- FIFO_DEPTH, 16, token FIFO entries; power of two, >= 4.

Ports:
- clki  in  1  clock.
- reset_clki  in  1  synchronous active-high reset.
- enable  in  1  gates acceptance of new frames.
- left_justify  in  1  1: pixel = datai[DATA_WIDTH-1 -: PIXEL_WIDTH]; 0: pixel = datai[PIXEL_WIDTH-1:0].
- hblank  in  16  extra lv-low cycles between rows.
- vblank  in  16  extra fv-low cycles between frames.
- fv_lead  in  8  extra fv-high/lv-low cycles before first row.
- dvi  in  1  input token valid.
- dtypei  in  `DTYPE_WIDTH  input token type (dtypes.v codes).
- datai  in  DATA_WIDTH  input token data.
- stall  out  1  registered backpressure to upstream.
- overflow  out  1  sticky: token arrived while FIFO full.
- frame_count  out  16  frames emitted (increments on fv rise).
- fv  out  1  frame valid.
- lv  out  1  line valid.
- dvo  out  1  pixel valid.
- datao  out  PIXEL_WIDTH  pixel data.

Behaviour:
- Reset: fv=lv=dvo=0, datao=0, stall=0, overflow=0, frame_count=0. FIFO empty, FSM IDLE, accept=0.
- Write side:
  - Only FRAME_START, ROW_START, PIXEL, ROW_END, FRAME_END tokens are written, as a 3-bit kind plus PIXEL_WIDTH payload. HEADER_START/HEADER/HEADER_END and unknown types are dropped.
  - accept flag: set when a FRAME_START arrives with enable=1, and that token is written. Cleared after FRAME_END is written.
  - With accept=0, every token other than an enabled FRAME_START is dropped. Dropping enable mid-frame lets the frame finish; raising enable mid-frame waits for the next FRAME_START.
  - Write while full: token dropped, overflow set until reset.
  - Simultaneous push and pop on a full FIFO: the push is still dropped (full evaluated before the pop).
  - stall registered: 1 when count >= FIFO_DEPTH-2 (2 cycles of slack).
- Read FSM, one pop maximum per cycle; all outputs registered:
  - IDLE: fv=0, lv=0.
    - Pop FRAME_START -> LEAD; fv=1, frame_count++.
    - Any other kind is popped and discarded.
  - LEAD: fv=1, lv=0 for fv_lead cycles (0 skips) -> FRAME.
  - FRAME: fv=1, lv=0.
    - Pop ROW_START -> LINE, lv=1.
    - Pop FRAME_END -> VBLANK, fv=0.
    - PIXEL/ROW_END popped and discarded.
  - LINE: lv=1.
    - Pop PIXEL: dvo=1, datao=payload.
    - FIFO empty: dvo=0, lv held high (gap within the row).
    - Pop ROW_END: lv=0 -> HBLANK.
    - Pop FRAME_END: lv=0 and fv=0 in the same cycle -> VBLANK.
    - ROW_START at head: not popped; treated as an implied ROW_END, lv=0 -> HBLANK.
    - FRAME_START at head: not popped; lv=fv=0 -> VBLANK.
  - HBLANK: lv=0 for hblank cycles (0 skips) -> FRAME.
  - VBLANK: fv=0 for vblank cycles (0 skips) -> IDLE.
  - hblank, vblank and fv_lead are sampled on entry to their state.
- Minimum gaps:
  - lv low between rows = hblank+1 cycles.
  - fv low between frames = vblank+1 cycles.
  - fv-rise to lv-rise = fv_lead+1 cycles.
- Latency: with FIFO empty and FSM in IDLE, FRAME_START accepted at edge N gives fv=1 in cycle N+2. Same 2-cycle latency for a pixel into an idle LINE.
- dvo is never 1 while lv=0. datao=0 whenever dvo=0.
- Counters saturate-free: frame_count wraps 0xFFFF->0.

Test Plan:
- 2x3 frame, hblank=2, vblank=3, fv_lead=1, left_justify=0, DATA 0x0ABC -> fv high, lv rises 2 cycles after fv, 3 dvo beats datao=0xABC each row, lv low 3 cycles between rows, fv low >=4 cycles after frame, frame_count=1.
- left_justify=1, PIXEL data 0xABC0 (16->12) -> datao=0xABC. HEADER_START/HEADER×10/HEADER_END between frames -> no output activity, no FIFO writes.
- Upstream ignores stall, burst of 20 tokens into FIFO_DEPTH=16 with read side stuck in a 100-cycle vblank -> stall=1 at count 14, overflow=1, exactly 16 tokens later emitted in order.
- Pixels delivered with 1-idle-cycle gaps -> lv stays high across gaps, dvo toggles 1/0, no early row end.
- enable=0 while FRAME_START arrives, enable=1 mid-frame -> nothing emitted until next FRAME_START. enable dropped mid-frame -> current frame completes fully.
- ROW_START with no ROW_END, then FRAME_END directly after pixels -> lv drops and HBLANK entered at the implied row end. On FRAME_END, fv and lv fall in the same cycle. reset_clki asserted mid-row -> all outputs 0 the next cycle, FIFO empty.
